// File: rtl/glitch_scheduler.sv
// glitch_scheduler
// ----------------
// Sequences one glitch campaign at a time for a bank of glitch_injector
// channels. A campaign is configured and armed with `start`, released by
// `trigger`, waits a programmable delay, then emits `cfg_count` pulses of
// `cfg_width` cycles separated by `cfg_gap` low cycles on either the
// `enable` (glitch_en) or `enable_specific` (glitch_specific) input of the
// selected channel. `done` pulses for one cycle when the campaign ends.
//
// Optional feature macro: GLITCH_SCHED_JITTER_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) free-runs and
//   its low three bits are added (saturating) to the first-pulse delay at
//   trigger time. When undefined the delay is exactly cfg_delay.
//
// Ports
//   clk             : rising-edge clock
//   reset_n         : synchronous active-low reset
//   start           : latch cfg_* and arm (IDLE only, target must be valid)
//   cfg_target      : injector channel index
//   cfg_specific    : 1 = drive glitch_specific, 0 = drive glitch_en
//   cfg_delay       : cycles from trigger to first pulse
//   cfg_width       : pulse width in cycles (0 behaves as 1)
//   cfg_gap         : low cycles between pulses
//   cfg_count       : number of pulses
//   trigger         : campaign release (ARMED only)
//   abort           : cancel campaign from any state, highest priority
//   glitch_en       : per-channel injector enable
//   glitch_specific : per-channel injector enable_specific
//   busy            : high in every state except IDLE
//   done            : one-cycle completion pulse
//   pulse_cnt       : pulses issued in the current or last campaign

module glitch_scheduler #(
   parameter int          NUM_TARGETS = 4,
   parameter int          CNT_W       = 16,
   parameter int          TGT_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [TGT_W-1:0]       cfg_target,
   input  logic                   cfg_specific,
   input  logic [CNT_W-1:0]       cfg_delay,
   input  logic [CNT_W-1:0]       cfg_width,
   input  logic [CNT_W-1:0]       cfg_gap,
   input  logic [CNT_W-1:0]       cfg_count,
   input  logic                   trigger,
   input  logic                   abort,
   output logic [NUM_TARGETS-1:0] glitch_en,
   output logic [NUM_TARGETS-1:0] glitch_specific,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       pulse_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DELAY,
      GLITCH,
      GAP,
      DONE
   } state_t;

   localparam logic [TGT_W:0] NUM_T = (TGT_W + 1)'(NUM_TARGETS);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       pcnt_d;
   logic [CNT_W-1:0]       pcnt_inc;
   logic                   load_cfg;
   logic                   target_ok;
   logic [TGT_W-1:0]       tgt_q;
   logic                   spec_q;
   logic [CNT_W-1:0]       delay_q;
   logic [CNT_W-1:0]       width_q;
   logic [CNT_W-1:0]       gap_q;
   logic [CNT_W-1:0]       count_q;
   logic [CNT_W-1:0]       first_delay;
   logic [NUM_TARGETS-1:0] sel;

   assign target_ok = ({1'b0, cfg_target} < NUM_T);
   assign pcnt_inc  = pulse_cnt + CNT_W'(1);

`ifdef GLITCH_SCHED_JITTER_EN
   logic [15:0]    lfsr_q;
   logic           lfsr_fb;
   logic [CNT_W:0] jit_sum;

   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Free-running jitter source; reseeded on every reset so a campaign
   // triggered at the same cycle offset after reset is reproducible.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      end
   end

   // Jitter only stretches the first delay, clamped at the counter maximum.
   assign jit_sum     = {1'b0, delay_q} + {{(CNT_W - 2){1'b0}}, lfsr_q[2:0]};
   assign first_delay = jit_sum[CNT_W] ? {CNT_W{1'b1}} : jit_sum[CNT_W-1:0];
`else
   logic unused_seed;

   assign unused_seed = ^LFSR_SEED;
   assign first_delay = delay_q;
`endif

   // One-hot decode of the latched target; the cfg latch only accepts
   // in-range targets so exactly one bit is set.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         sel[i] = (tgt_q == TGT_W'(i));
      end
   end

   // Next-state logic. A single down-counter is shared by DELAY, GLITCH and
   // GAP; every state leaves when the counter shows 1, so a load of N yields
   // N cycles in that state. Abort overrides everything else.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pcnt_d   = pulse_cnt;
      load_cfg = 1'b0;
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && target_ok) begin
                  load_cfg = 1'b1;
                  pcnt_d   = '0;
                  state_d  = ARMED;
               end
            end
            ARMED: begin
               if (trigger) begin
                  if (count_q == '0) begin
                     state_d = DONE;
                  end else if (first_delay != '0) begin
                     state_d = DELAY;
                     cnt_d   = first_delay;
                  end else begin
                     state_d = GLITCH;
                     cnt_d   = width_q;
                  end
               end
            end
            DELAY: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = GLITCH;
                  cnt_d   = width_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            GLITCH: begin
               if (cnt_q <= CNT_W'(1)) begin
                  pcnt_d = pcnt_inc;
                  if (pcnt_inc == count_q) begin
                     state_d = DONE;
                     cnt_d   = '0;
                  end else if (gap_q != '0) begin
                     state_d = GAP;
                     cnt_d   = gap_q;
                  end else begin
                     state_d = GLITCH;
                     cnt_d   = width_q;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = GLITCH;
                  cnt_d   = width_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, counters and configuration latch. Width 0 is stored as 1 so the
   // counter logic never has to special-case it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pulse_cnt <= '0;
         tgt_q     <= '0;
         spec_q    <= 1'b0;
         delay_q   <= '0;
         width_q   <= '0;
         gap_q     <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulse_cnt <= pcnt_d;
         if (load_cfg) begin
            tgt_q   <= cfg_target;
            spec_q  <= cfg_specific;
            delay_q <= cfg_delay;
            width_q <= (cfg_width == '0) ? CNT_W'(1) : cfg_width;
            gap_q   <= cfg_gap;
            count_q <= cfg_count;
         end
      end
   end

   // Outputs are registered from the next state so they line up exactly
   // with the state they describe and never glitch combinationally.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         glitch_en       <= '0;
         glitch_specific <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         glitch_en       <= (state_d == GLITCH && !spec_q) ? sel : '0;
         glitch_specific <= (state_d == GLITCH &&  spec_q) ? sel : '0;
         busy            <= (state_d != IDLE);
         done            <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_glitch_scheduler.sv
// tb_glitch_scheduler
// -------------------
// Scoreboard bench for glitch_scheduler. Stimulus tasks compute the expected
// per-cycle outputs of each campaign from the pulse timing rules (pulse k is
// high from T+1+delay+k*(width+gap) for width cycles, done follows the last
// pulse) and queue them; an independent monitor compares the DUT against the
// queue on every falling edge and requires quiet outputs elsewhere.

module tb_glitch_scheduler;

   localparam int NT = 4;
   localparam int CW = 16;
   localparam int TW = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [TW-1:0] cfg_target = '0;
   logic          cfg_specific = 1'b0;
   logic [CW-1:0] cfg_delay = '0;
   logic [CW-1:0] cfg_width = '0;
   logic [CW-1:0] cfg_gap = '0;
   logic [CW-1:0] cfg_count = '0;
   logic          trigger = 1'b0;
   logic          abort = 1'b0;
   logic [NT-1:0] glitch_en;
   logic [NT-1:0] glitch_specific;
   logic          busy;
   logic          done;
   logic [CW-1:0] pulse_cnt;

   glitch_scheduler #(
      .NUM_TARGETS(NT),
      .CNT_W      (CW),
      .TGT_W      (TW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .cfg_target     (cfg_target),
      .cfg_specific   (cfg_specific),
      .cfg_delay      (cfg_delay),
      .cfg_width      (cfg_width),
      .cfg_gap        (cfg_gap),
      .cfg_count      (cfg_count),
      .trigger        (trigger),
      .abort          (abort),
      .glitch_en      (glitch_en),
      .glitch_specific(glitch_specific),
      .busy           (busy),
      .done           (done),
      .pulse_cnt      (pulse_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [NT-1:0] en;
      logic [NT-1:0] spec;
      logic          done;
      logic          busy;
      logic [CW-1:0] pcnt;
   } exp_t;

   exp_t expQ[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   monOn = 1'b0;
   int   lastPcnt = 0;

   int   mTgt;
   bit   mSpec;
   int   mDelay;
   int   mWidth;
   int   mGap;
   int   mCount;

   always @(posedge clk) cyc++;

`ifdef GLITCH_SCHED_JITTER_EN
   logic [15:0] refLfsr = 16'hACE1;
   always @(posedge clk) begin
      if (!reset_n) refLfsr = 16'hACE1;
      else refLfsr = {refLfsr[14:0], refLfsr[15] ^ refLfsr[13] ^ refLfsr[12] ^ refLfsr[10]};
   end
   function automatic int jitter();
      return int'(refLfsr[2:0]);
   endfunction
`else
   function automatic int jitter();
      return 0;
   endfunction
`endif

   function automatic int doneCycle(int t);
      int w;
      w = (mWidth == 0) ? 1 : mWidth;
      if (mCount == 0) return t + 1;
      return t + 1 + mDelay + mCount * w + (mCount - 1) * mGap;
   endfunction

   // Expected outputs in cycle c of a campaign triggered in cycle t.
   function automatic exp_t expAt(int t, int c);
      exp_t e;
      int   w;
      int   s;
      w      = (mWidth == 0) ? 1 : mWidth;
      e.cyc  = c;
      e.en   = '0;
      e.spec = '0;
      e.busy = 1'b1;
      e.pcnt = '0;
      e.done = (c == doneCycle(t));
      for (int k = 0; k < mCount; k++) begin
         s = t + 1 + mDelay + k * (w + mGap);
         if (c >= s && c <= s + w - 1) begin
            if (mSpec) e.spec = NT'(1 << mTgt);
            else e.en = NT'(1 << mTgt);
         end
         if (s + w - 1 < c) e.pcnt = e.pcnt + 1'b1;
      end
      return e;
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushIdle(input int c, input int p);
      exp_t e;
      e.cyc  = c;
      e.en   = '0;
      e.spec = '0;
      e.done = 1'b0;
      e.busy = 1'b0;
      e.pcnt = CW'(p);
      expQ.push_back(e);
   endtask

   task automatic pushCampaign(input int t, input int cut, output int lastC);
      int d;
      d     = doneCycle(t);
      lastC = (cut >= 0 && cut < d) ? cut : d;
      for (int c = t + 1; c <= lastC; c++) expQ.push_back(expAt(t, c));
   endtask

   // Issue start for one cycle and expect ARMED (busy, nothing else) next.
   task automatic doStart(input int tgt, input bit spec, input int dly, input int wid,
                          input int gp, input int cnt);
      exp_t e;
      mTgt = tgt; mSpec = spec; mDelay = dly; mWidth = wid; mGap = gp; mCount = cnt;
      cfg_target   = TW'(tgt);
      cfg_specific = spec;
      cfg_delay    = CW'(dly);
      cfg_width    = CW'(wid);
      cfg_gap      = CW'(gp);
      cfg_count    = CW'(cnt);
      start        = 1'b1;
      e.cyc  = cyc + 1;
      e.en   = '0;
      e.spec = '0;
      e.done = 1'b0;
      e.busy = 1'b1;
      e.pcnt = '0;
      expQ.push_back(e);
      stepCycle();
      start        = 1'b0;
      cfg_target   = TW'($urandom_range(0, 3));
      cfg_specific = 1'($urandom_range(0, 1));
      cfg_delay    = CW'($urandom_range(0, 9));
      cfg_width    = CW'($urandom_range(0, 9));
      cfg_gap      = CW'($urandom_range(0, 9));
      cfg_count    = CW'($urandom_range(0, 9));
   endtask

   // One full campaign. abortMode: -1 none, -2 random point, >=0 offset
   // from the trigger cycle. noise issues a start during busy.
   task automatic applyStimulus(input int tgt, input bit spec, input int dly, input int wid,
                                input int gp, input int cnt, input int abortMode,
                                input bit noise);
      int t;
      int cut;
      int lastC;
      exp_t e;
      doStart(tgt, spec, dly, wid, gp, cnt);
      repeat ($urandom_range(0, 2)) stepCycle();
      mDelay  = mDelay + jitter();
      t       = cyc;
      trigger = 1'b1;
      if (abortMode == -2) cut = t + $urandom_range(0, doneCycle(t) - t);
      else if (abortMode >= 0) cut = t + abortMode;
      else cut = -1;
      pushCampaign(t, cut, lastC);
      e = expAt(t, lastC);
      pushIdle(lastC + 1, int'(e.pcnt));
      lastPcnt = int'(e.pcnt);
      abort = (cut == t);
      stepCycle();
      trigger = 1'b0;
      while (cyc <= lastC + 1) begin
         abort = (cyc == cut);
         start = noise && cut < 0 && cyc == t + 1;
         if (start) cfg_target = TW'($urandom_range(0, 3));
         stepCycle();
      end
      abort = 1'b0;
      start = 1'b0;
      stepCycle();
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (glitch_en !== e.en || glitch_specific !== e.spec || done !== e.done ||
          busy !== e.busy || pulse_cnt !== e.pcnt) begin
         errors++;
         $display("[TB] FAIL outputs cyc=%0d got en=%b spec=%b done=%b busy=%b pcnt=%0d want en=%b spec=%b done=%b busy=%b pcnt=%0d",
                  cyc, glitch_en, glitch_specific, done, busy, pulse_cnt,
                  e.en, e.spec, e.done, e.busy, e.pcnt);
      end
   endtask

   // Monitor: compares against the scoreboard when an entry is due and
   // otherwise requires the glitch outputs and done to be quiet.
   always @(negedge clk) begin
      if (monOn) begin
         checks++;
         if ((glitch_en & glitch_specific) != '0 || $countones(glitch_en | glitch_specific) > 1) begin
            errors++;
            $display("[TB] FAIL onehot cyc=%0d got en=%b spec=%b want at most one bit", cyc,
                     glitch_en, glitch_specific);
         end
         while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL stale cyc=%0d got entry for %0d want none pending", cyc, expQ[0].cyc);
            void'(expQ.pop_front());
         end
         if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            checkOutput(expQ.pop_front());
         end else begin
            checks++;
            if (glitch_en != '0 || glitch_specific != '0 || done != 1'b0) begin
               errors++;
               $display("[TB] FAIL quiet cyc=%0d got en=%b spec=%b done=%b want all 0", cyc,
                        glitch_en, glitch_specific, done);
            end
         end
      end
   end

   initial begin : main
      int t;
      int lastC;
      int wait_cycles;
      reset_n = 1'b0;
      repeat (2) stepCycle();
      monOn = 1'b1;
      pushIdle(cyc + 1, 0);
      stepCycle();
      reset_n = 1'b1;
      stepCycle();

      $display("[TB] directed campaigns");
      applyStimulus(2, 1'b0, 3, 2, 1, 2, -1, 1'b0);
      applyStimulus(1, 1'b1, 0, 0, 5, 1, -1, 1'b0);
      applyStimulus(3, 1'b0, 2, 2, 0, 3, -1, 1'b1);
      applyStimulus(0, 1'b0, 1, 3, 2, 3, 8, 1'b0);
      applyStimulus(1, 1'b0, 4, 1, 1, 0, -1, 1'b0);

      $display("[TB] ignored start and trigger");
      cfg_target = TW'(NT);
      cfg_count  = CW'(2);
      start      = 1'b1;
      pushIdle(cyc + 1, lastPcnt);
      stepCycle();
      start   = 1'b0;
      trigger = 1'b1;
      pushIdle(cyc + 1, lastPcnt);
      stepCycle();
      trigger = 1'b0;
      repeat (3) stepCycle();

      $display("[TB] reset during glitch");
      doStart(1, 1'b0, 1, 4, 0, 1);
      mDelay  = mDelay + jitter();
      t       = cyc;
      trigger = 1'b1;
      pushCampaign(t, t + 3, lastC);
      pushIdle(lastC + 1, 0);
      stepCycle();
      trigger = 1'b0;
      while (cyc < lastC) stepCycle();
      reset_n = 1'b0;
      stepCycle();
      reset_n = 1'b1;
      lastPcnt = 0;
      repeat (2) stepCycle();

      $display("[TB] random campaigns");
      for (int n = 0; n < 30; n++) begin
         applyStimulus($urandom_range(0, NT - 1), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? -2 : -1,
                       1'($urandom_range(0, 1)));
      end

      wait_cycles = 0;
      while (expQ.size() > 0 && wait_cycles < 50) begin
         stepCycle();
         wait_cycles++;
      end
      if (expQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain got %0d pending entries want 0", expQ.size());
      end
      monOn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/glitch_scheduler.md
# glitch_scheduler

Sequences glitch campaigns for a bank of `glitch_injector` instances in the dual-core glitch-protection test environment. A campaign is configured, armed, and then released by an external trigger, such as a core-event strobe. After a programmable delay it drives `enable` (random glitch) or `enable_specific` (forced value) into one selected injector. It emits a programmable number of pulses of programmable width and gap, then reports completion.

## Interface
Parameters:
- `NUM_TARGETS`, default 4: number of injector channels driven (≥1).
- `CNT_W`, default 16: width of the delay, width, gap and count fields and of the internal counters.
- `TGT_W`, default `$clog2(NUM_TARGETS)` (min 1): width of the target select.
- `LFSR_SEED`, default 16'hACE1: jitter LFSR reset value. Used only with `GLITCH_SCHED_JITTER_EN`.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: single-cycle request that latches `cfg_*`. Honoured only in IDLE.
- `cfg_target`, in, `TGT_W`: injector index to glitch.
- `cfg_specific`, in, 1: 1 selects `enable_specific`, 0 selects `enable`.
- `cfg_delay`, in, `CNT_W`: cycles from trigger to the first pulse.
- `cfg_width`, in, `CNT_W`: pulse width in cycles. 0 is treated as 1.
- `cfg_gap`, in, `CNT_W`: low cycles between pulses.
- `cfg_count`, in, `CNT_W`: number of pulses.
- `trigger`, in, 1: campaign release, sampled only in ARMED.
- `abort`, in, 1: cancels the campaign from any state.
- `glitch_en`, out, `NUM_TARGETS`: per-channel injector `enable`.
- `glitch_specific`, out, `NUM_TARGETS`: per-channel injector `enable_specific`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `pulse_cnt`, out, `CNT_W`: number of pulses issued in the current or last campaign.

## Operation
- States: IDLE, ARMED, DELAY, GLITCH, GAP, DONE.
- **IDLE:**
  - `start`=1 with `cfg_target < NUM_TARGETS` latches all `cfg_*`, clears `pulse_cnt` and moves to ARMED.
  - An out-of-range target ignores `start`; the block stays in IDLE.
- **ARMED:** on `trigger`=1:
  - count=0 → DONE, with no pulse.
  - Otherwise delay>0 → DELAY, loading the counter with delay.
  - Otherwise → GLITCH.
- **DELAY:** counts down. Leaves at the cycle the counter reaches 1 → GLITCH.
- **GLITCH:** drives the selected bit of exactly one output vector for width cycles, then increments `pulse_cnt`.
  - If `pulse_cnt` reaches count → DONE.
  - Else gap>0 → GAP.
  - Else the block re-enters GLITCH, so back-to-back pulses produce a continuous high output.
- **GAP:** counts down gap cycles → GLITCH.
- **DONE:** `done`=1 for one cycle → IDLE.
- `abort`=1 in any state → IDLE next cycle, all enables 0, no `done`. `pulse_cnt` holds its value. `abort` takes priority over `trigger`, `start` and counter expiry.
- `start` is ignored when not in IDLE. `trigger` is ignored when not in ARMED.
- `glitch_en & glitch_specific` is always 0. At most one bit of the OR of the two vectors is set.

## Timing
- Reset (`reset_n`=0 at an edge) → IDLE. All outputs are 0, counters are 0, and the LFSR is loaded with `LFSR_SEED`. Reset mid-campaign drops the enables on the next cycle.
- All outputs are registered, as Moore outputs of the state and counter registers.
- `start` in cycle S → ARMED and `busy`=1 in cycle S+1.
- `trigger` in cycle T:
  - The first pulse is high during cycles T+1+delay … T+delay+width.
  - Pulse k (0-based) starts at T+1+delay+k·(width+gap).
  - The last pulse is followed by DONE, with `done`=1 in the next cycle and `busy`=0 the cycle after.
- Counters are `CNT_W` bits and do not wrap. Maximum values give 2^CNT_W−1 cycles.

## Configuration
- `GLITCH_SCHED_JITTER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle.
  - On `trigger` acceptance, LFSR[2:0] (0–7) is added to the delay for the first pulse only. The sum saturates at 2^CNT_W−1.
- Not defined: no LFSR. The delay is exactly `cfg_delay` and timing is fully deterministic.

## Test plan
- target=2, specific=0, delay=3, width=2, gap=1, count=2, trigger at T:
  - `glitch_en`=4'b0100 during T+4..T+5 and T+7..T+8.
  - `done` at T+9.
  - `pulse_cnt`=2.
- specific=1, delay=0, width=0, count=1: `glitch_specific[target]` high only during T+1, and `glitch_en`=0 throughout.
- gap=0, width=2, count=3: selected enable continuously high for T+1+delay..T+delay+6, `done` one cycle after.
- `abort` asserted during the second pulse: enables 0 next cycle, IDLE, no `done`, `pulse_cnt`=1. `start` during busy and `trigger` in IDLE have no effect.
- `start` with cfg_target=NUM_TARGETS: stays IDLE. count=0 with trigger: `done` at T+1 with no pulse. `reset_n`=0 mid-GLITCH: all outputs 0 next cycle.
- Macro defined, delay=0, width=1: first pulse in T+1..T+8 exactly. Repeating from the same reset-to-trigger cycle offset reproduces an identical cycle.
